// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, controller state enum, xtime()   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_N      = 128;
  localparam int AES_ROUNDS = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // GF(2^8) multiply-by-x with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_rcon_gen : round-constant register, reloaded on init, xtime on   |
// | step.  Revision: 1.0                                                 |
// +----------------------------------------------------------------------+
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (init) begin
      rcon_d = RCON_INIT;
    end else if (step) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule
`default_nettype wire

// File: rtl/aes_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_round_sched : AES-128 iterative round sequencer with input and   |
// | output valid/ready handshakes.  Revision: 1.0                        |
// +----------------------------------------------------------------------+
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int N        = AES_N,
  parameter int ROUNDS   = AES_ROUNDS,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_key,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic         dp_final,
  output logic [7:0]   dp_rcon,
  output logic [3:0]   dp_round,
  input  logic [N-1:0] dp_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int            SW         = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [SW-1:0] SUB_LAST   = SW'(SBOX_LAT - 1);
  localparam logic [3:0]    ROUND_LAST = 4'(ROUNDS);

  state_e         state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [SW-1:0]  sub_q, sub_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           is_run, is_done, capture;

  // Plaintext and key feed the datapath directly; only the handshake matters here.
  logic unused_in;
  assign unused_in = ^{in_data, in_key};

  assign is_run      = (state_q == RUN);
  assign is_done     = (state_q == DONE);
  assign in_ready    = (state_q == IDLE) & ~out_valid_q & enb;
  assign dp_load     = in_valid & in_ready;
  assign dp_round_en = is_run & enb & (sub_q == SUB_LAST);
  assign dp_final    = is_run & (round_q == ROUND_LAST);
  assign dp_round    = round_q;
  assign busy        = is_run | is_done;
  assign capture     = is_done & enb;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (dp_load) begin
          state_d = RUN;
          round_d = 4'd1;
          sub_d   = '0;
        end
      end
      RUN: begin
        if (enb) begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (round_q == ROUND_LAST) begin
              state_d = DONE;
              round_d = 4'd0;
            end else begin
              round_d = round_q + 4'd1;
            end
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
      end
      DONE: begin
        if (enb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture has priority; a handshake cannot coincide since out_valid is low in DONE.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = dp_state;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      sub_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  aes_rcon_gen u_rcon (
    .clk  (clk),
    .rst  (rst),
    .init (dp_load),
    .step (dp_round_en),
    .rcon (dp_rcon)
  );

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_round_sched : two sequencer instances (SBOX_LAT 1 and 3), each |
// | with a behavioural AES round datapath.  Revision: 1.0                 |
// +----------------------------------------------------------------------+
module tb_aes_round_sched;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [7:0]   RC_TAB [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                            8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  logic clk, rst, enb, in_valid, out_ready, use3;
  logic [127:0] in_data, in_key;

  logic         in_ready1, dp_load1, round_en1, final1, out_valid1, busy1;
  logic [7:0]   rcon1;
  logic [3:0]   round1;
  logic [127:0] dps1, dpk1, out_data1;
  logic         in_ready3, dp_load3, round_en3, final3, out_valid3, busy3;
  logic [7:0]   rcon3;
  logic [3:0]   round3;
  logic [127:0] dps3, dpk3, out_data3;

  wire          w_in_ready  = use3 ? in_ready3  : in_ready1;
  wire          w_load      = use3 ? dp_load3   : dp_load1;
  wire          w_round_en  = use3 ? round_en3  : round_en1;
  wire          w_final     = use3 ? final3     : final1;
  wire          w_out_valid = use3 ? out_valid3 : out_valid1;
  wire          w_busy      = use3 ? busy3      : busy1;
  wire [7:0]    w_rcon      = use3 ? rcon3      : rcon1;
  wire [3:0]    w_round     = use3 ? round3     : round1;
  wire [127:0]  w_out_data  = use3 ? out_data3  : out_data1;

  int checks = 0;
  int failures = 0;

  int           obs_wait, obs_lat, obs_pulses, obs_final_cycles;
  logic [127:0] obs_ct;
  logic [7:0]   obs_rcon   [0:15];
  int           obs_pcyc   [0:15];
  logic         obs_pfinal [0:15];
  logic [3:0]   obs_pround [0:15];

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x2(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq = b;
    logic [7:0] inv = 8'h01;
    logic [7:0] r, s;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                           x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3 = k[31:0];
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [127:0] t = sub_shift(s);
    if (!fin) t = mix(t);
    return t ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 0; r < 10; r++) begin
      k = kexp(k, RC_TAB[r]);
      s = aes_round(s, k, r == 9);
    end
    return s;
  endfunction

  // ---------------- behavioural round datapaths ----------------
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dps1 <= '0; dpk1 <= '0;
    end else if (dp_load1) begin
      dps1 <= in_data ^ in_key; dpk1 <= in_key;
    end else if (round_en1) begin
      dps1 <= aes_round(dps1, kexp(dpk1, rcon1), final1);
      dpk1 <= kexp(dpk1, rcon1);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dps3 <= '0; dpk3 <= '0;
    end else if (dp_load3) begin
      dps3 <= in_data ^ in_key; dpk3 <= in_key;
    end else if (round_en3) begin
      dps3 <= aes_round(dps3, kexp(dpk3, rcon3), final3);
      dpk3 <= kexp(dpk3, rcon3);
    end
  end

  aes_round_sched #(.SBOX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid & ~use3), .in_ready(in_ready1),
    .in_data(in_data), .in_key(in_key), .dp_load(dp_load1), .dp_round_en(round_en1),
    .dp_final(final1), .dp_rcon(rcon1), .dp_round(round1), .dp_state(dps1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  aes_round_sched #(.SBOX_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid & use3), .in_ready(in_ready3),
    .in_data(in_data), .in_key(in_key), .dp_load(dp_load3), .dp_round_en(round_en3),
    .dp_final(final3), .dp_rcon(rcon3), .dp_round(round3), .dp_state(dps3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Offer one block, count cycles from the acceptance edge until out_valid.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input int stall_at, input int stall_len);
    bit acc = 0;
    obs_wait = -1; obs_lat = -1; obs_pulses = 0; obs_final_cycles = 0; obs_ct = '0;
    in_valid = 1'b1; in_data = pt; in_key = key; enb = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (w_load) begin acc = 1; obs_wait = w; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      for (int c = 1; c <= 300; c++) begin
        enb = !(c >= stall_at && c < stall_at + stall_len);
        @(negedge clk);
        if (w_final) obs_final_cycles++;
        if (w_round_en) begin
          if (obs_pulses < 16) begin
            obs_rcon[obs_pulses]   = w_rcon;
            obs_pcyc[obs_pulses]   = c;
            obs_pfinal[obs_pulses] = w_final;
            obs_pround[obs_pulses] = w_round;
          end
          obs_pulses++;
        end
        if (w_out_valid) begin obs_lat = c; obs_ct = w_out_data; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    enb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b1; use3 = 1'b0;
    in_data = '0; in_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid1); end
    checks++; if (out_data1 !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data1); end
    checks++; if (round1 !== 4'd0) begin failures++; $display("FAIL reset_round got=%0d want=0", round1); end
    checks++; if (rcon1 !== 8'h01) begin failures++; $display("FAIL reset_rcon got=%h want=01", rcon1); end
    checks++; if ({dp_load1, round_en1, final1, busy1} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {dp_load1, round_en1, final1, busy1}); end
    checks++; if ({busy3, out_valid3, round_en3} !== 3'b0) begin failures++; $display("FAIL reset_dut3 got=%b want=000", {busy3, out_valid3, round_en3}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_c1;
    use3 = 1'b0;
    run_block(C1_PT, C1_KEY, 0, 0);
    checks++; if (obs_ct !== C1_CT) begin failures++; $display("FAIL c1_ct got=%h want=%h", obs_ct, C1_CT); end
    checks++; if (obs_lat !== 12) begin failures++; $display("FAIL c1_latency got=%0d want=12", obs_lat); end
  endtask

  task automatic test_control_seq;
    use3 = 1'b0;
    run_block(C1_PT, C1_KEY, 0, 0);
    checks++; if (obs_pulses !== 10) begin failures++; $display("FAIL ctrl_pulses got=%0d want=10", obs_pulses); end
    checks++; if (obs_final_cycles !== 1) begin failures++; $display("FAIL ctrl_final_cycles got=%0d want=1", obs_final_cycles); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (obs_rcon[i] !== RC_TAB[i]) begin failures++; $display("FAIL ctrl_rcon[%0d] got=%h want=%h", i, obs_rcon[i], RC_TAB[i]); end
      checks++; if (obs_pround[i] !== 4'(i + 1)) begin failures++; $display("FAIL ctrl_round[%0d] got=%0d want=%0d", i, obs_pround[i], i + 1); end
      checks++; if (obs_pfinal[i] !== (i == 9)) begin failures++; $display("FAIL ctrl_final[%0d] got=%b want=%b", i, obs_pfinal[i], i == 9); end
      checks++; if (obs_pcyc[i] !== i + 1) begin failures++; $display("FAIL ctrl_cycle[%0d] got=%0d want=%0d", i, obs_pcyc[i], i + 1); end
    end
  endtask

  task automatic test_sbox_lat3;
    use3 = 1'b1;
    run_block(C1_PT, C1_KEY, 0, 0);
    checks++; if (obs_ct !== C1_CT) begin failures++; $display("FAIL lat3_ct got=%h want=%h", obs_ct, C1_CT); end
    checks++; if (obs_lat !== 32) begin failures++; $display("FAIL lat3_latency got=%0d want=32", obs_lat); end
    checks++; if (obs_pulses !== 10) begin failures++; $display("FAIL lat3_pulses got=%0d want=10", obs_pulses); end
    checks++; if (obs_final_cycles !== 3) begin failures++; $display("FAIL lat3_final_cycles got=%0d want=3", obs_final_cycles); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (obs_pcyc[i] !== 3 * (i + 1)) begin failures++; $display("FAIL lat3_cycle[%0d] got=%0d want=%0d", i, obs_pcyc[i], 3 * (i + 1)); end
      checks++; if (obs_rcon[i] !== RC_TAB[i]) begin failures++; $display("FAIL lat3_rcon[%0d] got=%h want=%h", i, obs_rcon[i], RC_TAB[i]); end
    end
    use3 = 1'b0;
  endtask

  task automatic test_stall;
    use3 = 1'b0;
    run_block(C1_PT, C1_KEY, 5, 4);
    checks++; if (obs_lat !== 16) begin failures++; $display("FAIL stall_latency got=%0d want=16", obs_lat); end
    checks++; if (obs_ct !== C1_CT) begin failures++; $display("FAIL stall_ct got=%h want=%h", obs_ct, C1_CT); end
    checks++; if (obs_pulses !== 10) begin failures++; $display("FAIL stall_pulses got=%0d want=10", obs_pulses); end
  endtask

  task automatic test_backpressure;
    int bad_data = 0, bad_ready = 0, bad_valid = 0;
    logic [127:0] pt2, k2;
    use3 = 1'b0;
    out_ready = 1'b0;
    run_block(C1_PT, C1_KEY, 0, 0);
    checks++; if (obs_ct !== C1_CT) begin failures++; $display("FAIL bp_ct got=%h want=%h", obs_ct, C1_CT); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_out_data !== C1_CT) bad_data++;
      if (w_in_ready !== 1'b0) bad_ready++;
      if (w_out_valid !== 1'b1) bad_valid++;
      @(posedge clk); #1;
    end
    checks++; if (bad_data !== 0) begin failures++; $display("FAIL bp_data_stable bad_cycles=%0d want=0", bad_data); end
    checks++; if (bad_ready !== 0) begin failures++; $display("FAIL bp_in_ready_low bad_cycles=%0d want=0", bad_ready); end
    checks++; if (bad_valid !== 0) begin failures++; $display("FAIL bp_out_valid_held bad_cycles=%0d want=0", bad_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2  = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(pt2, k2, 0, 0);
    checks++; if (obs_wait !== 0) begin failures++; $display("FAIL bp_next_accept wait=%0d want=0", obs_wait); end
    checks++; if (obs_ct !== aes_ref(pt2, k2)) begin failures++; $display("FAIL bp_second_ct got=%h want=%h", obs_ct, aes_ref(pt2, k2)); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pt, k;
    use3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(pt, k, 0, 0);
      checks++; if (obs_ct !== aes_ref(pt, k)) begin failures++; $display("FAIL b2b_ct[%0d] got=%h want=%h", i, obs_ct, aes_ref(pt, k)); end
      if (i > 0) begin
        checks++; if (obs_wait !== 0) begin failures++; $display("FAIL b2b_accept[%0d] wait=%0d want=0", i, obs_wait); end
      end
    end
  endtask

  task automatic test_random;
    logic [127:0] pt, k;
    int lat_p, len, at;
    for (int i = 0; i < 8; i++) begin
      use3  = i[0];
      lat_p = use3 ? 3 : 1;
      pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
      k     = {$urandom(), $urandom(), $urandom(), $urandom()};
      len   = $urandom_range(0, 4);
      at    = $urandom_range(1, 10 * lat_p + 1 - len);
      run_block(pt, k, at, len);
      checks++; if (obs_ct !== aes_ref(pt, k)) begin failures++; $display("FAIL rand_ct[%0d] got=%h want=%h", i, obs_ct, aes_ref(pt, k)); end
      checks++; if (obs_lat !== 10 * lat_p + 2 + len) begin failures++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, obs_lat, 10 * lat_p + 2 + len); end
    end
    use3 = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit hit = 0;
    use3 = 1'b0;
    in_valid = 1'b1; in_data = C1_PT; in_key = C1_KEY;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (w_load) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (w_round == 4'd5) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rmid_reach_round5 got=%b want=1", hit); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({w_busy, w_round_en, w_final, w_load, w_out_valid} !== 5'b0) begin failures++; $display("FAIL rmid_ctrl got=%b want=00000", {w_busy, w_round_en, w_final, w_load, w_out_valid}); end
    checks++; if (w_round !== 4'd0) begin failures++; $display("FAIL rmid_round got=%0d want=0", w_round); end
    checks++; if (w_rcon !== 8'h01) begin failures++; $display("FAIL rmid_rcon got=%h want=01", w_rcon); end
    checks++; if (w_out_data !== 128'h0) begin failures++; $display("FAIL rmid_out_data got=%h want=0", w_out_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_block(C1_PT, C1_KEY, 0, 0);
    checks++; if (obs_ct !== C1_CT) begin failures++; $display("FAIL rmid_after_ct got=%h want=%h", obs_ct, C1_CT); end
    checks++; if (obs_lat !== 12) begin failures++; $display("FAIL rmid_after_latency got=%0d want=12", obs_lat); end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_control_seq();
    test_sbox_lat3();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sched.md
# aes_round_sched

Sequencing controller for the iterative AES-128 encryption datapath. It accepts one plaintext/key pair per block over a valid/ready handshake and drives the round datapath's load, round-enable, final-round and round-constant controls for 10 rounds. It honours a per-round S-box latency and the global `enb` stall. It captures the ciphertext into an output buffer presented over a second valid/ready handshake. It sits between the system front end and the S-box/round datapath inside `top`.

## Interface
- `N`, 128: block and key width in bits.
- `ROUNDS`, 10: AES-128 round count.
- `SBOX_LAT`, 1: cycles per round (≥1); the datapath needs this many cycles before each round result is valid.

- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enb`  in  1  global enable; low freezes sequencing.
- `in_valid`  in  1  plaintext/key offered.
- `in_ready`  out  1  controller can accept a block.
- `in_data`  in  N  plaintext; forwarded to the datapath on load.
- `in_key`  in  N  cipher key; forwarded to the datapath on load.
- `dp_load`  out  1  datapath loads `state = in_data ^ in_key` and `key = in_key`.
- `dp_round_en`  out  1  datapath applies one round and advances its key schedule.
- `dp_final`  out  1  current round omits MixColumns (round 10).
- `dp_rcon`  out  8  round constant for the key-expansion step of the current round.
- `dp_round`  out  4  current round number, 1..10; 0 when idle.
- `dp_state`  in  N  datapath state register.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer takes ciphertext.
- `out_data`  out  N  ciphertext buffer.
- `busy`  out  1  a block is in flight (states RUN or DONE).

## Operation
- FSM states:
  - IDLE → RUN when `in_valid & in_ready`.
  - RUN → DONE after round 10's `dp_round_en` cycle.
  - DONE → IDLE after one cycle.
- Handshake and load:
  - `in_ready = (state==IDLE) & ~out_valid & enb`.
  - `dp_load = in_valid & in_ready`, combinational, asserted in the acceptance cycle only.
- RUN sequencing:
  - `round` starts at 1 and `sub` at 0.
  - Each enabled cycle, `sub` increments.
  - When `sub==SBOX_LAT-1`: `dp_round_en`=1, `sub`→0, `round` increments.
- Round constants:
  - `dp_rcon` is valid whenever state is RUN.
  - Sequence is 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
  - Generated as `xtime` of the previous value, reducing with 0x1B on bit-7 overflow.
- `dp_final` = RUN & (`round==ROUNDS`).
- DONE: `out_data <= dp_state`; `out_valid` is set at the same edge.
- Output: `out_valid` clears on `out_valid & out_ready`; `out_data` holds until the next capture.
- `enb` low:
  - RUN freezes `round`, `sub` and `rcon`, and forces `dp_round_en`=0.
  - DONE does not capture.
  - `in_ready`=0.
  - The output handshake still completes.
- Stray `in_valid` while busy is ignored; the upstream source must hold the data until `in_ready`.
- Reset (any time, including mid-block):
  - State goes to IDLE and the in-flight block is discarded.
  - Outputs go to `out_valid`=0, `out_data`=0, `round`=0, `rcon`=01, `sub`=0.
  - `dp_load`, `dp_round_en`, `dp_final` and `busy` are 0.

## Timing
- Acceptance edge E0, all cycles with `enb`=1:
  - `dp_round_en` is high in the last cycle of each SBOX_LAT-cycle round slot, first at cycle SBOX_LAT.
  - The round-10 pulse is at cycle 10·SBOX_LAT.
  - DONE occupies cycle 10·SBOX_LAT+1.
  - `out_valid` rises in cycle 10·SBOX_LAT+2, which is 12 cycles for SBOX_LAT=1.
- Each stalled `enb`=0 cycle in RUN or DONE adds exactly one cycle of latency.
- Throughput with `out_ready` tied high: one block per 10·SBOX_LAT+3 cycles. `out_valid` and `in_ready` are mutually exclusive, so the next accept can occur in the cycle after the output handshake.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_N`=128 and `AES_ROUNDS`=10.
  - The state enum (IDLE, RUN, DONE).
  - Function `xtime(byte)`.
  - Constant `RCON_INIT`=8'h01.
- One sub-module: `aes_rcon_gen` (clk, rst, init, step → rcon[7:0]). `init` on `dp_load`, `step` on `dp_round_en`.
- The controller itself is the FSM, the `round`/`sub` counters and the output buffer.

## Test plan
- FIPS-197 C.1 with a behavioural round-datapath model, SBOX_LAT=1:
  - Stimulus: key 000102…0f, plaintext 00112233445566778899aabbccddeeff.
  - Response: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a with `out_valid` 12 cycles after acceptance.
- Control sequence:
  - Sample `dp_rcon` at each `dp_round_en`: exactly 01,02,04,08,10,20,40,80,1B,36.
  - Exactly 10 `dp_round_en` pulses.
  - `dp_final` high only with round 10.
- SBOX_LAT=3:
  - Pulses at cycles 3,6,…,30.
  - `out_valid` at cycle 32.
- Stall and backpressure:
  - Drop `enb` for 4 cycles mid-RUN: latency becomes 16 and the ciphertext is unchanged.
  - Hold `out_ready`=0 for 20 cycles: `out_data` stable, `in_ready`=0 throughout.
  - A second block is accepted the cycle after the handshake.
- Reset mid-operation:
  - Assert `rst`=0 at round 5: all outputs take their reset values immediately.
  - After release, a fresh C.1 vector completes correctly.
